// File: rtl/bus_int_arb_pkg.sv
// -----------------------------------------------------------------------------
// bus_int_arb_pkg
// Shared definitions for the bus interrupt arbiter: FSM state encoding,
// register window offsets, number of interrupt sources and the MASK reset
// value.
// Optional feature macro used by the arbiter: BUS_INT_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
package bus_int_arb_pkg;

    localparam int unsigned NUM_SRC = 4;

    // Offsets within the 3-register window, relative to BASE_ADDR
    localparam logic [7:0] OFFSET_MASK    = 8'd0;
    localparam logic [7:0] OFFSET_VECTOR  = 8'd1;
    localparam logic [7:0] OFFSET_PENDING = 8'd2;

    localparam logic [7:0] MASK_RESET_VAL = 8'h0F;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRaise    = 2'd1,
        StAck      = 2'd2,
        StWaitDrop = 2'd3
    } arb_state_e;

endpackage

// File: rtl/int_arb_pick.sv
// -----------------------------------------------------------------------------
// int_arb_pick
// Combinational winner selection: scans req starting at index 'start' and
// wrapping modulo NUM_SRC; the first set bit found wins.
// Ports:
//   req   - masked request vector
//   start - index where the search begins (0 gives fixed lowest-index priority)
//   id    - winning index (only meaningful when any=1)
//   any   - at least one request is set
// -----------------------------------------------------------------------------
module int_arb_pick
    import bus_int_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         start,
    output logic [1:0]         id,
    output logic               any
);

    logic [1:0] idx;

    // Scan from the far end back toward 'start' so the candidate closest to
    // 'start' is the last one assigned and therefore wins.
    always_comb begin
        id  = start;
        any = 1'b0;
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = start + 2'(i);
            if (req[idx]) begin
                id  = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_interrupt_arbiter.sv
// -----------------------------------------------------------------------------
// bus_interrupt_arbiter
// Collects four level-sensitive peripheral interrupt requests, picks one,
// raises a single CPU interrupt line and completes an ack handshake with the
// granted source. Registers are reachable over a simple processor bus:
//   BASE_ADDR+0 MASK    (rw)  low nibble gates SRC_RAISE
//   BASE_ADDR+1 VECTOR  (ro)  {valid, 5'b0, id}
//   BASE_ADDR+2 PENDING (ro)  {4'b0, SRC_RAISE & MASK[3:0]}
// Ports:
//   CLK           - system clock, rising edge
//   RESET         - asynchronous active-low reset
//   BUS_DATA      - shared data bus, driven only on the cycle after a read
//   BUS_ADDR      - processor address
//   BUS_WE        - processor write strobe
//   SRC_RAISE     - peripheral interrupt requests (bit 0 is the mouse)
//   SRC_ACK       - one-cycle acknowledge pulse to the granted source
//   CPU_INT_RAISE - interrupt line to the processor
//   CPU_INT_ACK   - processor acknowledge
// Configuration:
//   BUS_INT_ARB_ROUND_ROBIN_EN - when defined, the search starts one past the
//   last acknowledged source; otherwise priority is fixed (index 0 highest).
// -----------------------------------------------------------------------------
module bus_interrupt_arbiter
    import bus_int_arb_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR    = 8'hA8,
    // Only the low 4 bits are used: the WAIT_DROP counter is 4 bits wide
    parameter int unsigned DROP_TIMEOUT = 15
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire logic [7:0]    BUS_DATA,
    input  logic [7:0]         BUS_ADDR,
    input  logic               BUS_WE,
    input  logic [NUM_SRC-1:0] SRC_RAISE,
    output logic [NUM_SRC-1:0] SRC_ACK,
    output logic               CPU_INT_RAISE,
    input  logic               CPU_INT_ACK
);

    arb_state_e         state_q;
    logic [7:0]         mask_q;
    logic               vec_valid_q;
    logic [1:0]         vec_id_q;
    logic [3:0]         cnt_q;
    logic [NUM_SRC-1:0] src_ack_q;
    logic               int_raise_q;
    logic [7:0]         rdata_q;
    logic               drive_q;

    logic [NUM_SRC-1:0] req;
    logic [1:0]         start;
    logic [1:0]         pick_id;
    logic               pick_any;
    logic [7:0]         offset;
    logic               in_win;
    logic               rd_hit;
    logic               wr_mask;
    logic [7:0]         reg_rdata;

    assign req = SRC_RAISE & mask_q[NUM_SRC-1:0];

`ifdef BUS_INT_ARB_ROUND_ROBIN_EN
    logic [1:0] last_grant_q;
    assign start = last_grant_q + 2'd1;
`else
    assign start = 2'd0;
`endif

    int_arb_pick u_pick (
        .req   (req),
        .start (start),
        .id    (pick_id),
        .any   (pick_any)
    );

    // Bus decode
    assign offset  = BUS_ADDR - BASE_ADDR;
    assign in_win  = (offset <= OFFSET_PENDING);
    assign rd_hit  = in_win && !BUS_WE;
    assign wr_mask = BUS_WE && (offset == OFFSET_MASK);

    always_comb begin
        reg_rdata = 8'h00;
        case (offset)
            OFFSET_MASK:    reg_rdata = mask_q;
            OFFSET_VECTOR:  reg_rdata = {vec_valid_q, 5'b0, vec_id_q};
            OFFSET_PENDING: reg_rdata = {4'b0, req};
            default:        reg_rdata = 8'h00;
        endcase
    end

    assign BUS_DATA      = drive_q ? rdata_q : 8'bz;
    assign SRC_ACK       = src_ack_q;
    assign CPU_INT_RAISE = int_raise_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= StIdle;
            mask_q       <= MASK_RESET_VAL;
            vec_valid_q  <= 1'b0;
            vec_id_q     <= 2'd0;
            cnt_q        <= 4'd0;
            src_ack_q    <= '0;
            int_raise_q  <= 1'b0;
            rdata_q      <= 8'h00;
            drive_q      <= 1'b0;
`ifdef BUS_INT_ARB_ROUND_ROBIN_EN
            last_grant_q <= 2'd3;
`endif
        end else begin
            src_ack_q <= '0;

            // Read data is captured on the addressing edge and presented for
            // the following cycle only.
            drive_q <= rd_hit;
            if (rd_hit) begin
                rdata_q <= reg_rdata;
            end
            if (wr_mask) begin
                mask_q <= BUS_DATA;
            end

            case (state_q)
                StIdle: begin
                    if (pick_any) begin
                        vec_valid_q <= 1'b1;
                        vec_id_q    <= pick_id;
                        int_raise_q <= 1'b1;
                        state_q     <= StRaise;
                    end
                end
                StRaise: begin
                    // Ack takes precedence over a simultaneous withdrawal
                    if (CPU_INT_ACK) begin
                        src_ack_q   <= NUM_SRC'(1) << vec_id_q;
                        vec_valid_q <= 1'b0;
                        int_raise_q <= 1'b0;
                        state_q     <= StAck;
                    end else if (!req[vec_id_q]) begin
                        vec_valid_q <= 1'b0;
                        int_raise_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StAck: begin
                    cnt_q   <= 4'(DROP_TIMEOUT);
                    state_q <= StWaitDrop;
`ifdef BUS_INT_ARB_ROUND_ROBIN_EN
                    last_grant_q <= vec_id_q;
`endif
                end
                StWaitDrop: begin
                    // Count of 1 means this is the last permitted cycle
                    if (!SRC_RAISE[vec_id_q] || (cnt_q <= 4'd1)) begin
                        cnt_q   <= 4'd0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interrupt_arbiter.sv
module tb_bus_interrupt_arbiter;

    localparam logic [7:0]  BASE = 8'hA8;
    localparam int unsigned TMO  = 15;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    wire  [7:0] BUS_DATA;
    logic [7:0] BUS_ADDR = 8'h00;
    logic       BUS_WE = 1'b0;
    logic [3:0] SRC_RAISE = 4'b0;
    logic [3:0] SRC_ACK;
    logic       CPU_INT_RAISE;
    logic       CPU_INT_ACK = 1'b0;

    logic       tb_drv = 1'b0;
    logic [7:0] tb_wdata = 8'h00;
    assign BUS_DATA = tb_drv ? tb_wdata : 8'bz;

    bus_interrupt_arbiter #(
        .BASE_ADDR    (BASE),
        .DROP_TIMEOUT (TMO)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .BUS_DATA      (BUS_DATA),
        .BUS_ADDR      (BUS_ADDR),
        .BUS_WE        (BUS_WE),
        .SRC_RAISE     (SRC_RAISE),
        .SRC_ACK       (SRC_ACK),
        .CPU_INT_RAISE (CPU_INT_RAISE),
        .CPU_INT_ACK   (CPU_INT_ACK)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int    val;
        int    due;
        string name;
    } exp_t;

    exp_t rd_q[$];
    exp_t ack_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0] mask_m = 8'h0F;
    int         last_grant_m = 3;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Winner rule: first requesting index found scanning upward from st, mod 4
    function automatic int pick(input logic [3:0] rq, input int st);
        for (int i = 0; i < 4; i++) begin
            if (rq[(st + i) % 4]) return (st + i) % 4;
        end
        return -1;
    endfunction

    function automatic int start_m();
`ifdef BUS_INT_ARB_ROUND_ROBIN_EN
        return (last_grant_m + 1) % 4;
`else
        return 0;
`endif
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        BUS_ADDR = a;
        BUS_WE   = 1'b1;
        tb_wdata = d;
        tb_drv   = 1'b1;
        tick();
        BUS_WE   = 1'b0;
        tb_drv   = 1'b0;
        BUS_ADDR = 8'h00;
        if (a == BASE) mask_m = d;
    endtask

    // Data appears on the bus during the cycle after the addressing edge
    task automatic bus_read(input logic [7:0] a, input int exp, input string nm);
        exp_t e;
        e.val  = exp;
        e.due  = cyc + 1;
        e.name = nm;
        rd_q.push_back(e);
        BUS_ADDR = a;
        tick();
        BUS_ADDR = 8'h00;
        tick();
    endtask

    task automatic do_ack(input int w);
        exp_t e;
        e.val  = 1 << w;
        e.due  = cyc + 1;
        e.name = "src_ack";
        ack_q.push_back(e);
        CPU_INT_ACK = 1'b1;
        tick();
        CPU_INT_ACK = 1'b0;
        last_grant_m = w;
    endtask

    // Number of falling edges until CPU_INT_RAISE == lvl, or -1 when exceeded
    task automatic wait_raise(input logic lvl, input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            @(negedge CLK);
            if (CPU_INT_RAISE == lvl) begin
                n = i;
                break;
            end
        end
        tick();
    endtask

    // Full request/grant/ack cycle; nhold grants re-raise via the drop timeout
    task automatic transaction(input logic [3:0] r, input logic [7:0] m, input int nhold);
        logic [3:0] rq;
        int         w;
        int         n;
        bus_write(BASE, m);
        bus_read(BASE, int'(mask_m), "mask_readback");
        rq = r & m[3:0];
        SRC_RAISE = r;
        w = pick(rq, start_m());
        wait_raise(1'b1, 4, n);
        check("raise_latency", n, 2);
        bus_read(BASE + 8'd2, int'({4'b0, rq}), "pending");
        for (int g = 0; g <= nhold; g++) begin
            bus_read(BASE + 8'd1, int'({1'b1, 5'b0, 2'(w)}), "vector_valid");
            repeat ($urandom_range(0, 3)) tick();
            do_ack(w);
            if (g < nhold) begin
                // 1 ACK cycle + TMO WAIT_DROP cycles + 1 IDLE cycle, seen one edge later
                wait_raise(1'b1, 40, n);
                check("timeout_reraise", n, int'(TMO) + 3);
                w = pick(rq, start_m());
            end
        end
        bus_read(BASE + 8'd1, int'({6'b0, 2'(w)}), "vector_after_ack");
        repeat ($urandom_range(0, 3)) tick();
        SRC_RAISE = 4'b0;
        repeat (3) tick();
        check("idle_after_drop", int'(CPU_INT_RAISE), 0);
    endtask

    // Scoreboard monitor: compares bus read data and SRC_ACK pulses
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                e = rd_q.pop_front();
                check(e.name, int'(BUS_DATA), e.val);
            end
            if (ack_q.size() > 0 && ack_q[0].due == cyc) begin
                e = ack_q.pop_front();
                check(e.name, int'(SRC_ACK), e.val);
            end else if (SRC_ACK != 4'b0) begin
                check("unexpected_src_ack", int'(SRC_ACK), 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int         n;
        logic [3:0] r;
        logic [7:0] m;

        // Asynchronous reset with no clock edge
        #3 RESET = 1'b0;
        #1;
        check("reset_cpu_int_raise", int'(CPU_INT_RAISE), 0);
        check("reset_src_ack", int'(SRC_ACK), 0);

        // Mouse request present at reset release
        SRC_RAISE = 4'b0001;
        tick();
        tick();
        RESET = 1'b1;
        wait_raise(1'b1, 4, n);
        check("first_raise_latency", n, 2);
        bus_read(BASE + 8'd1, 8'h80, "vector_mouse");
        bus_read(BASE + 8'd2, 8'h01, "pending_mouse");
        bus_read(BASE, 8'h0F, "mask_reset");
        do_ack(0);
        bus_read(BASE + 8'd1, 8'h00, "vector_cleared");
        SRC_RAISE = 4'b0;
        repeat (3) tick();
        check("idle_after_mouse", int'(CPU_INT_RAISE), 0);

        // Two sources, request held through the timeout
        transaction(4'b1010, 8'h0F, 1);

        // MASK write withdraws the mouse request
        SRC_RAISE = 4'b0001;
        wait_raise(1'b1, 4, n);
        check("mask_case_raise", n, 2);
        bus_write(BASE, 8'h0E);
        wait_raise(1'b0, 3, n);
        check("mask_withdraw_drop", n, 2);
        bus_read(BASE + 8'd2, 8'h00, "pending_masked");
        bus_read(BASE + 8'd1, 8'h00, "vector_withdrawn");
        SRC_RAISE = 4'b0;
        bus_write(BASE, 8'h0F);

        // Source withdraws without ack
        SRC_RAISE = 4'b0010;
        wait_raise(1'b1, 4, n);
        check("drop_case_raise", n, 2);
        SRC_RAISE = 4'b0;
        wait_raise(1'b0, 3, n);
        check("src_withdraw_drop", n, 2);
        bus_read(BASE + 8'd1, 8'h01, "vector_src_withdrawn");

        // Ack and drop in the same cycle: ack wins
        SRC_RAISE = 4'b0100;
        wait_raise(1'b1, 4, n);
        check("ackdrop_case_raise", n, 2);
        SRC_RAISE = 4'b0;
        do_ack(2);
        repeat (3) tick();
        check("idle_after_ackdrop", int'(CPU_INT_RAISE), 0);
        bus_read(BASE + 8'd1, 8'h02, "vector_after_ackdrop");

        // Writes outside MASK are ignored
        bus_write(BASE + 8'd1, 8'hFF);
        bus_write(BASE + 8'd2, 8'hFF);
        bus_write(BASE + 8'd3, 8'h00);
        bus_write(BASE - 8'd1, 8'h00);
        bus_read(BASE, 8'h0F, "mask_unchanged");
        bus_read(BASE + 8'd1, 8'h02, "vector_unchanged");

        // Randomised transactions
        for (int it = 0; it < 30; it++) begin
            do begin
                r = 4'($urandom);
                m = 8'($urandom);
            end while ((r & m[3:0]) == 4'b0);
            transaction(r, m, ($urandom_range(0, 2) == 0) ? 1 : 0);
        end

        // Reset in the middle of a handshake
        bus_write(BASE, 8'h0F);
        SRC_RAISE = 4'b0001;
        wait_raise(1'b1, 4, n);
        check("reset_case_raise", n, 2);
        CPU_INT_ACK = 1'b1;
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1;
        check("midreset_cpu_int_raise", int'(CPU_INT_RAISE), 0);
        check("midreset_src_ack", int'(SRC_ACK), 0);
        tick();
        CPU_INT_ACK = 1'b0;
        SRC_RAISE = 4'b0;
        tick();
        RESET = 1'b1;
        mask_m = 8'h0F;
        last_grant_m = 3;
        tick();
        check("post_reset_idle", int'(CPU_INT_RAISE), 0);
        bus_read(BASE + 8'd1, 8'h00, "vector_after_reset");
        bus_read(BASE, 8'h0F, "mask_after_reset");
        transaction(4'b1111, 8'h0F, 0);

        repeat (3) tick();
        check("read_queue_drained", rd_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_interrupt_arbiter.md
BUS_INTERRUPT_ARBITER -- requirements
Module: bus_interrupt_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 8'hA8: base of the 3-register window (A8 MASK rw, A9 VECTOR ro, AA PENDING ro).
REQ-002 SHALL have parameter DROP_TIMEOUT, default 15: maximum cycles spent in WAIT_DROP.
REQ-003 SHALL have port CLK, input, 1: single system clock; all logic is on the rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port BUS_DATA, inout, 8: shared processor data bus, tristated when not driving.
REQ-006 SHALL have port BUS_ADDR, input, 8: processor address.
REQ-007 SHALL have port BUS_WE, input, 1: processor write strobe.
REQ-008 SHALL have port SRC_RAISE, input, 4: level interrupt requests from peripherals; bit 0 is the mouse.
REQ-009 SHALL have port SRC_ACK, output, 4: one-cycle acknowledge pulse to the granted source.
REQ-010 SHALL have port CPU_INT_RAISE, output, 1: single interrupt line to the processor.
REQ-011 SHALL have port CPU_INT_ACK, input, 1: processor acknowledge.

Function
REQ-012 SHALL define req = SRC_RAISE & MASK[3:0]; PENDING reads {4'b0, req}.
REQ-013 SHALL implement the FSM states IDLE, RAISE, ACK and WAIT_DROP.
REQ-014 IDLE: when req != 0, SHALL latch the winner id into VECTOR, set VECTOR[7] (valid) and enter RAISE on the next edge.
REQ-015 RAISE: SHALL hold CPU_INT_RAISE=1; on CPU_INT_ACK=1 it SHALL enter ACK.
REQ-016 RAISE: if req[id] drops with no ack, SHALL clear valid, drop CPU_INT_RAISE the next cycle and return to IDLE (withdrawn request); ack SHALL win if ack and drop occur in the same cycle.
REQ-017 ACK: SHALL pulse SRC_ACK[id] for exactly one cycle, clear VECTOR valid, drop CPU_INT_RAISE and enter WAIT_DROP.
REQ-018 WAIT_DROP: SHALL return to IDLE once SRC_RAISE[id]==0, or after DROP_TIMEOUT cycles via a 4-bit down-counter, whichever comes first.
REQ-019 Latency: req asserted at edge n SHALL give CPU_INT_RAISE=1 after edge n+1 and SRC_ACK pulse in the cycle after the ack is sampled.
REQ-020 Default priority SHALL be fixed: lowest index wins.
REQ-021 Bus reads: address in window and BUS_WE=0 SHALL drive register data on BUS_DATA one cycle later; otherwise BUS_DATA SHALL be Z.
REQ-022 Bus writes to MASK SHALL take effect the next cycle; writes to VECTOR, PENDING or out-of-window addresses SHALL be ignored.
REQ-023 A MASK write that clears mask[id] during RAISE SHALL behave as a withdrawn request per REQ-016.
REQ-024 VECTOR SHALL read {valid, 5'b0, id[1:0]}.

Reset
REQ-025 Asserting RESET SHALL immediately force: state IDLE, MASK=8'h0F, VECTOR=8'h00, SRC_ACK=0, CPU_INT_RAISE=0, BUS_DATA=Z, counter=0, last_grant=3.
REQ-026 Reset mid-handshake SHALL discard the in-flight grant without issuing SRC_ACK.

Configuration
REQ-027 With BUS_INT_ARB_ROUND_ROBIN_EN defined, the search SHALL start at last_grant+1 mod 4, and last_grant SHALL update in ACK.
REQ-028 Without BUS_INT_ARB_ROUND_ROBIN_EN, priority SHALL be fixed and no last_grant register SHALL exist.

Structure
REQ-029 A shared package bus_int_arb_pkg SHALL hold the state encoding enum, register offsets (MASK=0, VECTOR=1, PENDING=2), NUM_SRC=4 and the MASK reset value.
REQ-030 Winner selection SHALL be a sub-module int_arb_pick (req[3:0], start[1:0] -> id[1:0], any).

Verification
REQ-031 Drive SRC_RAISE=4'b0001 at reset release and ack after 3 cycles -> CPU_INT_RAISE high from cycle 2, VECTOR=8'h80, single SRC_ACK=4'b0001 pulse, then return to IDLE when the source drops.
REQ-032 Drive SRC_RAISE=4'b1010 -> VECTOR=8'h81; after ack and drop with the request held, next VECTOR is 8'h81 (fixed priority) or 8'h83 (round-robin).
REQ-033 Write MASK=8'h0E via BUS_ADDR=8'hA8 while id 0 is in RAISE -> CPU_INT_RAISE=0 the next cycle, no SRC_ACK, PENDING reads 8'h00.
REQ-034 Have the source ignore SRC_ACK and stay high -> WAIT_DROP exits after 15 cycles and re-raises.
REQ-035 Assert RESET during RAISE -> all outputs reach reset values with no clock edge; read VECTOR afterward returns 8'h00; no SRC_ACK pulse.
